mem_resp: RTL and testbench
===========================

// Module: mem_resp
// PURPOSE
//  Memory-bus responder at the far end of the CPU's MAB/MDB interface. Decodes a word-addressed
//  RAM window and services CPU read/write requests with a programmable wait-state count.
//  Drives read data back on MDB_out with a one-cycle MEM_RDY completion pulse.
//  Sits beside mem_space on the data bus; the bus mux uses MEM_SEL to steer MDB_out.
// PARAMETERS
//  SIZE         16       data bus width (fixed at 16 for this core)
//  BASE_ADDR    16'h0200 first byte address of the window (DEPTH*2-aligned)
//  DEPTH        64       window depth in 16-bit words (power of 2, 2..1024)
//  WAIT_STATES  1        extra cycles inserted before completion (0..15)
// PORTS
//  clk       in   1   clock, all logic on rising edge
//  rst       in   1   reset, synchronous, active-high
//  MAB_in    in   16  byte address from CPU
//  MDB_in    in   16  write data from CPU
//  MW        in   1   1 = write, 0 = read
//  BW        in   1   1 = byte access, 0 = word access
//  MEM_REQ   in   1   access request; held with MAB_in/MDB_in/MW/BW stable until MEM_RDY
//  MDB_out   out  16  read data, valid while MEM_RDY=1, held until next completion
//  MEM_RDY   out  1   one-cycle completion pulse
//  MEM_SEL   out  1   high from accept through completion of an in-window access
//  MEM_ERR   out  1   misaligned-word error pulse (MEM_RESP_ALIGN_ERR_EN only; else tied 0)
// BEHAVIOUR
//  - Hit: MEM_REQ=1 and BASE_ADDR <= MAB_in < BASE_ADDR+2*DEPTH; idx = (MAB_in-BASE_ADDR)>>1.
//  - Miss: request ignored; MEM_SEL, MEM_RDY stay 0; no state change.
//  - FSM IDLE -> (hit) WAIT (WAIT_STATES>0, counter=WAIT_STATES-1) or DONE (WAIT_STATES=0).
//    WAIT -> DONE when counter==0, else decrement. DONE -> IDLE unconditionally.
//  - Accept latches addr/data/MW/BW; later input changes are ignored for that access.
//  - Latency: hit sampled at edge N -> MEM_RDY high during cycle N+1+WAIT_STATES, exactly 1 cycle.
//  - REQ still high during DONE is not re-accepted; next accept earliest in the following IDLE cycle.
//    Throughput: one access per WAIT_STATES+2 cycles.
//  - Write commits on the edge entering DONE. MDB_out is unchanged on writes.
//  - BW=1 write: addr[0]=0 -> low byte, addr[0]=1 -> high byte (MDB_in[7:0] used); other byte kept.
//  - BW=1 read: MDB_out = {8'h00, selected byte}, zero-extended. BW=0 read: full word.
//  - Word access with addr[0]=1 (macro off): addr[0] ignored, aligned down.
//  - Reset: storage cleared to 0, state IDLE, MDB_out=0, MEM_RDY=0, MEM_SEL=0, MEM_ERR=0.
//    Reset mid-access aborts it: no commit, no MEM_RDY.
//  - Top address BASE_ADDR+2*DEPTH-1 is a hit (high byte of last word); +2*DEPTH is a miss.
// CONFIGURATION
//  MEM_RESP_ALIGN_ERR_EN defined: word access with addr[0]=1 still runs the full FSM and latency.
//    No write commits. MDB_out=16'h0000. MEM_ERR pulses coincident with MEM_RDY.
//  Undefined: aligned-down behaviour above; MEM_ERR tied 0.
// STRUCTURE
//  Shared package/include mem_defs: FSM state localparams (IDLE=2'd0, WAIT=2'd1, DONE=2'd2),
//    bus width constants, byte-lane select macro.
//  Sub-module mem_resp_array: DEPTH x 16 storage, sync write with 2-bit byte-enable,
//    comb read by idx.
//  The FSM, decode and lane logic stay in mem_resp.
// TESTING
//  1 Reset, then word write 16'hBEEF @16'h0200, word read @16'h0200, WAIT_STATES=1
//    -> MEM_RDY 2 cycles after accept; read returns 16'hBEEF.
//  2 Byte write 8'h12 @16'h0203 over word 16'hBEEF @16'h0202, then word read @16'h0202
//    -> 16'h12EF. Byte read @16'h0203 -> 16'h0012.
//  3 REQ @16'h01FE and @16'h0280 (DEPTH=64)
//    -> no MEM_SEL/MEM_RDY for 10 cycles. @16'h027F byte read -> MEM_RDY.
//  4 WAIT_STATES=0, REQ held high for 3 back-to-back reads
//    -> MEM_RDY at cycles 1, 3, 5 after first accept; no double-accept.
//  5 Assert rst during WAIT of a write of 16'h5555 -> no MEM_RDY; later read returns 16'h0000.
//  6 MEM_RESP_ALIGN_ERR_EN: word write 16'hAAAA @16'h0201
//    -> MEM_ERR=1 with MEM_RDY. Read @16'h0200 -> unchanged. Macro off -> write lands @16'h0200.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the mem_resp memory-bus responder.
//  - bus / byte widths and wait-state counter width
//  - FSM state encoding (IDLE=0, WAIT=1, DONE=2)
//  - lane_be: byte-lane enable select for word / byte accesses
package mem_resp_pkg;

  localparam int unsigned BUS_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word access enables both lanes; byte access picks the lane from addr[0].
  function automatic logic [1:0] lane_be(input logic bw, input logic a0);
    if (!bw) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_resp_if.sv
// CPU MAB/MDB request/response bundle for mem_resp.
//  master (CPU side) : drives MAB_in, MDB_in, MW, BW, MEM_REQ
//  slave  (responder): drives MDB_out, MEM_RDY, MEM_SEL, MEM_ERR
interface mem_resp_if;
  import mem_resp_pkg::*;

  logic [BUS_W-1:0] MAB_in;
  logic [BUS_W-1:0] MDB_in;
  logic             MW;
  logic             BW;
  logic             MEM_REQ;
  logic [BUS_W-1:0] MDB_out;
  logic             MEM_RDY;
  logic             MEM_SEL;
  logic             MEM_ERR;

  modport master (
    output MAB_in, MDB_in, MW, BW, MEM_REQ,
    input  MDB_out, MEM_RDY, MEM_SEL, MEM_ERR
  );

  modport slave (
    input  MAB_in, MDB_in, MW, BW, MEM_REQ,
    output MDB_out, MEM_RDY, MEM_SEL, MEM_ERR
  );
endinterface

// File: rtl/mem_resp_array.sv
// DEPTH x 16-bit storage for mem_resp.
//  clk   : clock
//  clr   : synchronous clear of every word
//  we    : write strobe, be selects the lanes written
//  idx   : word index for both the write and the combinational read
//  wdata : write data (both lanes presented, be decides)
//  rdata : combinational read of word idx
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [1:0]       be,
  input  logic [AW-1:0]    idx,
  input  logic [BUS_W-1:0] wdata,
  output logic [BUS_W-1:0] rdata
);

  logic [BUS_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      if (be[0]) mem[idx][BYTE_W-1:0]     <= wdata[BYTE_W-1:0];
      if (be[1]) mem[idx][BUS_W-1:BYTE_W] <= wdata[BUS_W-1:BYTE_W];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_resp.sv
// Memory-bus responder: word-addressed RAM window on the CPU MAB/MDB bus
// with a programmable wait-state count and a one-cycle MEM_RDY pulse.
//  clk, rst : clock, synchronous active-high reset
//  bus      : mem_resp_if.slave (MAB_in, MDB_in, MW, BW, MEM_REQ in;
//             MDB_out, MEM_RDY, MEM_SEL, MEM_ERR out)
// Optional feature macro: MEM_RESP_ALIGN_ERR_EN -- misaligned word accesses
// complete with MEM_ERR, no commit and MDB_out=0. Without it the address is
// aligned down and MEM_ERR is tied low.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int unsigned SIZE        = 16,
  parameter logic [15:0] BASE_ADDR   = 16'h0200,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic      clk,
  input logic      rst,
  mem_resp_if.slave bus
);

  localparam int unsigned     AW       = $clog2(DEPTH);
  localparam logic [16:0]     WIN_LO   = {1'b0, BASE_ADDR};
  localparam logic [16:0]     WIN_HI   = WIN_LO + 17'(2 * DEPTH);
  localparam logic [WCNT_W-1:0] CNT_INIT =
    (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;

  if (SIZE != BUS_W)                   $error("mem_resp: SIZE must be 16");
  if (WAIT_STATES > 15)                $error("mem_resp: WAIT_STATES out of range");
  if (DEPTH < 2 || DEPTH > 1024)       $error("mem_resp: DEPTH out of range");

  state_t            state;
  logic [WCNT_W-1:0] cnt;
  logic [BUS_W-1:0]  a_addr, a_data;
  logic              a_mw, a_bw;

  logic              hit, accept, enter_done, misalign, we;
  logic [BUS_W-1:0]  c_addr, c_data;
  logic              c_mw, c_bw;
  logic [AW-1:0]     idx;
  logic [1:0]        be;
  logic [BUS_W-1:0]  wdata, rword, rdata_lane;

  logic              rdy_q, sel_q;
  logic [BUS_W-1:0]  out_q;

  assign hit    = bus.MEM_REQ && ({1'b0, bus.MAB_in} >= WIN_LO) && ({1'b0, bus.MAB_in} < WIN_HI);
  assign accept = (state == IDLE) && hit;
  assign enter_done = (accept && (WAIT_STATES == 0)) || ((state == WAIT) && (cnt == '0));

  // With zero wait states the access completes on the accepting edge, before
  // the latches are loaded, so the datapath works from the live bus in IDLE.
  assign c_addr = (state == IDLE) ? bus.MAB_in : a_addr;
  assign c_data = (state == IDLE) ? bus.MDB_in : a_data;
  assign c_mw   = (state == IDLE) ? bus.MW     : a_mw;
  assign c_bw   = (state == IDLE) ? bus.BW     : a_bw;

  assign idx   = AW'((c_addr - BASE_ADDR) >> 1);
  assign be    = lane_be(c_bw, c_addr[0]);
  assign wdata = c_bw ? {c_data[BYTE_W-1:0], c_data[BYTE_W-1:0]} : c_data;

`ifdef MEM_RESP_ALIGN_ERR_EN
  assign misalign = !c_bw && c_addr[0];
`else
  assign misalign = 1'b0;
`endif

  assign we = enter_done && c_mw && !misalign && !rst;

  assign rdata_lane = c_bw ? {8'h00, (c_addr[0] ? rword[BUS_W-1:BYTE_W] : rword[BYTE_W-1:0])}
                           : rword;

  mem_resp_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .clr   (rst),
    .we    (we),
    .be    (be),
    .idx   (idx),
    .wdata (wdata),
    .rdata (rword)
  );

`ifdef MEM_RESP_ALIGN_ERR_EN
  logic err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_addr <= '0;
      a_data <= '0;
      a_mw   <= 1'b0;
      a_bw   <= 1'b0;
      rdy_q  <= 1'b0;
      sel_q  <= 1'b0;
      out_q  <= '0;
`ifdef MEM_RESP_ALIGN_ERR_EN
      err_q  <= 1'b0;
`endif
    end else begin
      rdy_q <= 1'b0;
`ifdef MEM_RESP_ALIGN_ERR_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: if (accept) begin
          a_addr <= bus.MAB_in;
          a_data <= bus.MDB_in;
          a_mw   <= bus.MW;
          a_bw   <= bus.BW;
          sel_q  <= 1'b1;
          cnt    <= CNT_INIT;
          state  <= (WAIT_STATES == 0) ? DONE : WAIT;
        end
        WAIT: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        DONE: begin
          state <= IDLE;
          sel_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (enter_done) begin
        rdy_q <= 1'b1;
`ifdef MEM_RESP_ALIGN_ERR_EN
        err_q <= misalign;
`endif
        if (misalign)  out_q <= '0;
        else if (!c_mw) out_q <= rdata_lane;
      end
    end
  end

  assign bus.MDB_out = out_q;
  assign bus.MEM_RDY = rdy_q;
  assign bus.MEM_SEL = sel_q;
`ifdef MEM_RESP_ALIGN_ERR_EN
  assign bus.MEM_ERR = err_q;
`else
  assign bus.MEM_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp: two instances (WAIT_STATES=1 and WAIT_STATES=0) on a
// shared clock/reset, a reference model of the RAM window, and per-instance
// scoreboards popped on every MEM_RDY pulse.
module tb_mem_resp;
  import mem_resp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_resp_if bus1();
  mem_resp_if bus0();

  mem_resp #(.SIZE(16), .BASE_ADDR(16'h0200), .DEPTH(64), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  mem_resp #(.SIZE(16), .BASE_ADDR(16'h0200), .DEPTH(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  typedef struct {
    string       tag;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t sb1[$];
  exp_t sb0[$];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [15:0] mdl [2][64];
  logic [15:0] last_out [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 64; i++) mdl[w][i] = 16'h0000;
      last_out[w] = 16'h0000;
    end
  endtask

  task automatic model_step(input int w, input logic [15:0] addr, input logic [15:0] data,
                            input logic mw, input logic bw,
                            output logic [15:0] eo, output logic ee);
    int idx;
    logic [15:0] word;
    idx = int'((addr - 16'h0200) >> 1);
    ee  = 1'b0;
`ifdef MEM_RESP_ALIGN_ERR_EN
    if (!bw && addr[0]) ee = 1'b1;
`endif
    word = mdl[w][idx];
    if (ee) begin
      eo = 16'h0000;
    end else if (mw) begin
      if (bw) begin
        if (addr[0]) word[15:8] = data[7:0];
        else         word[7:0]  = data[7:0];
      end else begin
        word = data;
      end
      mdl[w][idx] = word;
      eo = last_out[w];
    end else begin
      eo = bw ? {8'h00, (addr[0] ? word[15:8] : word[7:0])} : word;
    end
    last_out[w] = eo;
  endtask

  task automatic drive(input int w, input logic [15:0] addr, input logic [15:0] data,
                       input logic mw, input logic bw, input logic req);
    if (w == 1) begin
      bus1.MAB_in = addr; bus1.MDB_in = data; bus1.MW = mw; bus1.BW = bw; bus1.MEM_REQ = req;
    end else begin
      bus0.MAB_in = addr; bus0.MDB_in = data; bus0.MW = mw; bus0.BW = bw; bus0.MEM_REQ = req;
    end
  endtask

  function automatic logic rdy_of(input int w);
    return (w == 1) ? bus1.MEM_RDY : bus0.MEM_RDY;
  endfunction

  function automatic logic sel_of(input int w);
    return (w == 1) ? bus1.MEM_SEL : bus0.MEM_SEL;
  endfunction

  // One in-window access: push expectation, hold request until MEM_RDY,
  // check latency and MEM_SEL, then let the responder return to IDLE.
  task automatic access(input int w, input string tag, input logic [15:0] addr,
                        input logic [15:0] data, input logic mw, input logic bw);
    logic [15:0] eo;
    logic ee;
    int unsigned n;
    model_step(w, addr, data, mw, bw, eo, ee);
    if (w == 1) sb1.push_back('{tag, eo, ee});
    else        sb0.push_back('{tag, eo, ee});
    @(negedge clk);
    drive(w, addr, data, mw, bw, 1'b1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check_eq({tag, "_sel"}, 32'(sel_of(w)), 32'd1);
    end while (!rdy_of(w) && n < 20);
    check_eq({tag, "_lat"}, n, (w == 1) ? 32'd2 : 32'd1);
    drive(w, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_eq({tag, "_sel_off"}, 32'(sel_of(w)), 32'd0);
  endtask

  task automatic miss1(input string tag, input logic [15:0] addr);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    drive(1, addr, 16'hDEAD, 1'b1, 1'b0, 1'b1);
    repeat (10) begin
      @(posedge clk); #1;
      seen = seen | bus1.MEM_SEL | bus1.MEM_RDY;
    end
    check_eq(tag, 32'(seen), 32'd0);
    drive(1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && bus1.MEM_RDY) begin
      if (sb1.size() == 0) check_eq("rdy1_unexpected", 32'(bus1.MEM_RDY), 32'd0);
      else begin
        e = sb1.pop_front();
        check_eq(e.tag, 32'(bus1.MDB_out), 32'(e.data));
        check_eq({e.tag, "_err"}, 32'(bus1.MEM_ERR), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst && bus0.MEM_RDY) begin
      if (sb0.size() == 0) check_eq("rdy0_unexpected", 32'(bus0.MEM_RDY), 32'd0);
      else begin
        e = sb0.pop_front();
        check_eq(e.tag, 32'(bus0.MDB_out), 32'(e.data));
        check_eq({e.tag, "_err"}, 32'(bus0.MEM_ERR), 32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [15:0] b2b_addr [3];
    int          rdy_at   [3];
    int unsigned nr;
    logic        seen;
    logic [15:0] eo;
    logic        ee;

    do_reset();
    #1;
    check_eq("rst_out1", 32'(bus1.MDB_out), 32'd0);
    check_eq("rst_rdy1", 32'(bus1.MEM_RDY), 32'd0);
    check_eq("rst_sel1", 32'(bus1.MEM_SEL), 32'd0);
    check_eq("rst_err1", 32'(bus1.MEM_ERR), 32'd0);
    check_eq("rst_out0", 32'(bus0.MDB_out), 32'd0);

    // basic word write / read
    access(1, "t1_wr",     16'h0200, 16'hBEEF, 1'b1, 1'b0);
    access(1, "t1_rd",     16'h0200, 16'h0000, 1'b0, 1'b0);

    // byte lanes
    access(1, "t2_wr",     16'h0202, 16'hBEEF, 1'b1, 1'b0);
    access(1, "t2_bwr_hi", 16'h0203, 16'hFF12, 1'b1, 1'b1);
    access(1, "t2_rd",     16'h0202, 16'h0000, 1'b0, 1'b0);
    access(1, "t2_brd_hi", 16'h0203, 16'h0000, 1'b0, 1'b1);
    access(1, "t2_brd_lo", 16'h0202, 16'h0000, 1'b0, 1'b1);
    access(1, "t2_bwr_lo", 16'h0202, 16'hAB34, 1'b1, 1'b1);
    access(1, "t2_rd2",    16'h0202, 16'h0000, 1'b0, 1'b0);

    // window edges
    miss1("t3_miss_lo", 16'h01FE);
    miss1("t3_miss_hi", 16'h0280);
    access(1, "t3_top_wr", 16'h027E, 16'hA55A, 1'b1, 1'b0);
    access(1, "t3_top_rd", 16'h027F, 16'h0000, 1'b0, 1'b1);

    // zero wait states: setup then back-to-back reads with REQ held
    access(0, "t4_wr0", 16'h0210, 16'h1111, 1'b1, 1'b0);
    access(0, "t4_wr1", 16'h0212, 16'h2222, 1'b1, 1'b0);
    access(0, "t4_wr2", 16'h0214, 16'h3333, 1'b1, 1'b0);
    b2b_addr[0] = 16'h0210; b2b_addr[1] = 16'h0212; b2b_addr[2] = 16'h0214;
    for (int i = 0; i < 3; i++) begin
      rdy_at[i] = 99;
      model_step(0, b2b_addr[i], 16'h0000, 1'b0, 1'b0, eo, ee);
      sb0.push_back('{$sformatf("t4_b2b%0d", i), eo, ee});
    end
    @(negedge clk);
    drive(0, b2b_addr[0], 16'h0000, 1'b0, 1'b0, 1'b1);
    nr = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus0.MEM_RDY) begin
        if (nr < 3) rdy_at[nr] = k;
        nr++;
        if (nr < 3) bus0.MAB_in = b2b_addr[nr];
        else        bus0.MEM_REQ = 1'b0;
      end
    end
    check_eq("t4_rdy_count", nr, 32'd3);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("t4_rdy_at%0d", i), 32'(rdy_at[i]), 32'(2 * i));

    // reset in the middle of a write
    @(negedge clk);
    drive(1, 16'h0204, 16'h5555, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_eq("t5_sel_wait", 32'(bus1.MEM_SEL), 32'd1);
    rst = 1'b1;
    drive(1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk); #1;
    check_eq("t5_rdy_abort", 32'(bus1.MEM_RDY), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | bus1.MEM_RDY | bus1.MEM_SEL;
    end
    check_eq("t5_quiet", 32'(seen), 32'd0);
    access(1, "t5_rd",    16'h0204, 16'h0000, 1'b0, 1'b0);
    access(1, "t5_rd_cl", 16'h0200, 16'h0000, 1'b0, 1'b0);

    // misaligned word access
    access(1, "t6_seed",  16'h0200, 16'h1234, 1'b1, 1'b0);
    access(1, "t6_mis_wr", 16'h0201, 16'hAAAA, 1'b1, 1'b0);
    access(1, "t6_rd",    16'h0200, 16'h0000, 1'b0, 1'b0);
    access(1, "t6_mis_rd", 16'h0201, 16'h0000, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb1_drain", sb1.size(), 32'd0);
    check_eq("sb0_drain", sb0.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
